// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART transmit path.
// The frame format is fixed at 8N1, LSB first.
package uart_pkg;

    localparam int   UART_DATA_BITS = 8;
    localparam logic UART_LINE_IDLE = 1'b1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        START = ST_START,
        DATA  = ST_DATA,
        STOP  = ST_STOP
    } uart_tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through output.
// Read-first: a pop and a push on the same edge leave the occupancy unchanged.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // NOTE: the storage array has no reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter fed from an internal FIFO, with frame-boundary flow control.
// tx is registered from the current state, so the line lags the state machine by one cycle.
module uart_tx
    import uart_pkg::*;
#(
    parameter int BAUD_COUNT = 645,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    data_in,
    input  logic                          valid_in,
    output logic                          ready_out,
    input  logic                          hold_in,
    output logic                          tx,
    output logic                          busy_out,
    output logic [$clog2(FIFO_DEPTH):0]   count_out
);

    localparam int BW = $clog2(BAUD_COUNT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_COUNT - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(UART_DATA_BITS - 1);

    uart_tx_state_t            state;
    logic [BW-1:0]             baud_cnt;
    logic [2:0]                bit_idx;
    logic [UART_DATA_BITS-1:0] shift_reg;
    logic [UART_DATA_BITS-1:0] fifo_head;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      fifo_push;
    logic                      fifo_pop;
    logic                      baud_done;
    logic                      at_boundary;
    logic                      tx_next;

    assign ready_out   = !fifo_full;
    assign fifo_push   = valid_in && !fifo_full;
    assign baud_done   = (baud_cnt == BAUD_LAST);
    // hold_in is only looked at between frames, so a frame in flight always completes
    assign at_boundary = (state == IDLE) || (state == STOP && baud_done);
    assign fifo_pop    = at_boundary && !fifo_empty && !hold_in;
    assign busy_out    = (state != IDLE) || !fifo_empty;

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (data_in),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count_out)
    );

    // NOTE: tx_next gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        tx_next = UART_LINE_IDLE;
        case (state)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_reg[0];
            default: ;
        endcase
    end

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx        <= UART_LINE_IDLE;
        end else begin
            tx       <= tx_next;
            baud_cnt <= baud_done ? '0 : baud_cnt + 1'b1;
            unique case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (fifo_pop) begin
                        shift_reg <= fifo_head;
                        state     <= START;
                    end
                end
                START: begin
                    if (baud_done) begin
                        state   <= DATA;
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        shift_reg <= shift_reg >> 1;
                        if (bit_idx == LAST_BIT) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                STOP: begin
                    // back-to-back frames: reload straight into START with no idle cycle
                    if (baud_done) begin
                        if (fifo_pop) begin
                            shift_reg <= fifo_head;
                            state     <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a frame-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_uart_tx;

    localparam int BAUD  = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int FRAME = 10 * BAUD;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    data_in = 8'h00;
    logic          valid_in = 1'b0;
    logic          hold_in = 1'b0;
    logic          ready_out;
    logic          tx;
    logic          busy_out;
    logic [CW-1:0] count_out;

    int errors = 0;
    int checks = 0;

    uart_tx #(
        .BAUD_COUNT (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .hold_in   (hold_in),
        .tx        (tx),
        .busy_out  (busy_out),
        .count_out (count_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: a byte queue plus "cycles into the current frame".
    // Line value for frame cycle k is bit k/BAUD of {stop, data[7:0], start}.
    byte unsigned m_q[$];
    logic         m_active = 1'b0;
    int           m_cnt = 0;
    logic [7:0]   m_byte = 8'h00;
    logic         m_tx = 1'b1;
    logic         m_live = 1'b0;
    logic         m_pop;
    logic         m_push;

    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return b[idx-1];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_active = 1'b0;
            m_cnt    = 0;
            m_tx     = 1'b1;
            m_live   = 1'b1;
        end else begin
            m_tx   = m_active ? frame_bit(m_byte, m_cnt / BAUD) : 1'b1;
            m_pop  = (!m_active || m_cnt == FRAME - 1) && m_q.size() > 0 && !hold_in;
            m_push = valid_in && m_q.size() < DEPTH;
            if (m_active) begin
                m_cnt++;
                if (m_cnt == FRAME) m_active = 1'b0;
            end
            if (m_pop) begin
                m_byte   = m_q.pop_front();
                m_active = 1'b1;
                m_cnt    = 0;
            end
            if (m_push) m_q.push_back(data_in);
        end
        #1;
        if (m_live) begin
            check("model_tx", tx, m_tx);
            check("model_count", count_out, m_q.size());
            check("model_ready", ready_out, m_q.size() < DEPTH);
            check("model_busy", busy_out, m_active || m_q.size() > 0);
        end
    end

    task automatic push_byte(input logic [7:0] b);
        @(negedge clk);
        data_in  = b;
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (busy_out !== 1'b0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check(name, busy_out, 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [9:0] a5_wave = 10'b1101001010;
        logic [7:0] burst [4] = '{8'h00, 8'hFF, 8'h3C, 8'hC3};
        int         busy_cycles;

        repeat (2) @(negedge clk);
        check("reset_tx", tx, 1);
        check("reset_count", count_out, 0);
        check("reset_busy", busy_out, 0);
        check("reset_ready", ready_out, 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single byte 0xA5: start bit on the line two edges after the push
        push_byte(8'hA5);
        check("single_count_after_push", count_out, 1);
        check("single_busy_rise", busy_out, 1);
        @(negedge clk);
        check("single_count_after_pop", count_out, 0);
        check("single_tx_before_start", tx, 1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("single_bit%0d", k), tx, a5_wave[k]);
            if (k == 9) check("single_busy_late", busy_out, 1);
            repeat (3) @(negedge clk);
        end
        check("single_busy_fall", busy_out, 0);
        drain("single_drain");

        // Burst of four bytes: one frame right after another
        @(negedge clk);
        valid_in = 1'b1;
        foreach (burst[i]) begin
            data_in = burst[i];
            @(negedge clk);
        end
        valid_in = 1'b0;
        check("burst_count", count_out, 3);
        check("burst_ready", ready_out, 1);
        busy_cycles = 0;
        while (busy_out === 1'b1 && busy_cycles < 400) begin
            busy_cycles++;
            @(negedge clk);
        end
        check("burst_busy_cycles", busy_cycles, 158);
        drain("burst_drain");

        // Overflow with hold asserted: only four bytes accepted
        hold_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            data_in = 8'h10 + 8'(i);
            @(negedge clk);
        end
        valid_in = 1'b0;
        check("overflow_count", count_out, 4);
        check("overflow_ready", ready_out, 0);
        check("overflow_tx_held", tx, 1);
        hold_in = 1'b0;
        drain("overflow_drain");

        // Hold: line stays idle until release, then start bit two cycles later
        hold_in = 1'b1;
        push_byte(8'h55);
        repeat (50) @(negedge clk);
        check("hold_tx_idle", tx, 1);
        check("hold_count", count_out, 1);
        hold_in = 1'b0;
        @(negedge clk);
        check("hold_release_tx1", tx, 1);
        @(negedge clk);
        check("hold_release_tx2", tx, 0);
        push_byte(8'hE7);
        repeat (10) @(negedge clk);
        hold_in = 1'b1;
        repeat (60) @(negedge clk);
        check("hold_mid_withheld_count", count_out, 1);
        check("hold_mid_withheld_tx", tx, 1);
        hold_in = 1'b0;
        drain("hold_drain");

        // Reset during DATA bit 3 with another byte queued
        push_byte(8'h96);
        push_byte(8'h69);
        repeat (17) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset_tx", tx, 1);
        check("midreset_count", count_out, 0);
        check("midreset_busy", busy_out, 0);
        repeat (60) @(negedge clk);
        check("midreset_quiet_tx", tx, 1);
        check("midreset_quiet_busy", busy_out, 0);

        // Randomized traffic with occasional hold toggles
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            valid_in = ($urandom_range(0, 3) == 0);
            data_in  = 8'($urandom);
            if ($urandom_range(0, 49) == 0) hold_in = ~hold_in;
        end
        valid_in = 1'b0;
        hold_in  = 1'b0;
        drain("random_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
